serial_sub8: RTL

Bit-serial, multi-cycle subtractor. It computes D = A − B − Bin, the inverse operation of the team's combinational 8-bit adder. It processes one bit per clock, LSB first, so the datapath stays small for area-constrained lab builds. A start/busy/done handshake lets a control FSM (e.g. heap compare/swap sequencing) issue a subtraction and wait for the result.

---
 rtl/serial_sub8_pkg.sv | 16 +
 rtl/serial_sub8_if.sv | 20 ++
 rtl/serial_sub8_fsub1.sv | 11 +
 rtl/serial_sub8.sv | 125 ++++++++++++
 4 files changed

// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM encoding,
// default operand width and the signed-overflow helper.
package serial_sub8_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Overflow of a - b: operands differ in sign and the result sign differs from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage

// File: rtl/serial_sub8_if.sv
// Request/result bundle of the serial subtractor; the controller drives the
// master side, the subtractor implements the slave side.
interface serial_sub8_if
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;

    modport master (output start, A, B, Bin, input busy, done, D, Bout, V);
    modport slave  (input start, A, B, Bin, output busy, done, D, Bout, V);
endinterface

// File: rtl/serial_sub8_fsub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fsub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock, LSB first, with a
// start/busy/done handshake. Results are written only when entering DONE.
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub8_if.slave bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;

    logic             bit_d_s;
    logic             bit_bout_s;
    logic [WIDTH-1:0] res_next_s;

    fsub1 u_fsub1 (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .d    (bit_d_s),
        .bout (bit_bout_s)
    );

    assign res_next_s = {bit_d_s, res_q[WIDTH-1:1]};

    // Next-state, datapath shift and result-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        res_d   = res_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sa_d    = bus.A;
                    sb_d    = bus.B;
                    br_d    = bus.Bin;
                    cnt_d   = {CNT_W{1'b0}};
                    amsb_d  = bus.A[WIDTH-1];
                    bmsb_d  = bus.B[WIDTH-1];
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = bit_bout_s;
                res_d = res_next_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    d_d     = res_next_s;
                    bout_d  = bit_bout_s;
                    v_d     = sub_ovf(amsb_q, bmsb_q, bit_d_s);
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            br_q    <= 1'b0;
            res_q   <= {WIDTH{1'b0}};
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            d_q     <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            res_q   <= res_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;

endmodule
